// File: rtl/wram_cdc_dma_if.sv
// CDC source handshake plus WRAM write-port bundle used by the CDC->WRAM DMA engine.
// master: DMA engine side (drives src_ready and the dma_* write port, sees src_* and wram_hold).
// slave : environment side (CDC buffer feeding src_*, WRAM controller consuming dma_* and driving wram_hold).
interface wram_cdc_dma_if #(
   parameter int ADDR_W = 19
);
   logic              src_valid;
   logic [15:0]       src_data;
   logic              src_ready;
   logic              wram_hold;
   logic [ADDR_W-1:0] dma_addr;
   logic [15:0]       dma_dat;
   logic              dma_ce_wram;
   logic              dma_we;

   modport master (
      input  src_valid, src_data, wram_hold,
      output src_ready, dma_addr, dma_dat, dma_ce_wram, dma_we
   );

   modport slave (
      output src_valid, src_data, wram_hold,
      input  src_ready, dma_addr, dma_dat, dma_ce_wram, dma_we
   );
endinterface

// File: rtl/wram_cdc_dma.sv
// CDC host-data -> Word-RAM DMA: pulls 16-bit words from the CDC buffer and writes them to WRAM.
// Latency: first WRAM strobe 1 tick after a word is accepted; one word per WR_TICKS+1 ticks at best.
// Backpressure: src_ready only in FETCH; wram_hold freezes an in-flight write; sub_sync=0 freezes all.
// Ports: clk_asic/cd_rst_n clock and async active-low reset; sub_sync tick enable;
//        start/abort/dst_addr/len control; busy/done/remain status;
//        bus (master): src_valid/src_data/src_ready source, wram_hold, dma_addr/dma_dat/dma_ce_wram/dma_we.
module wram_cdc_dma #(
   parameter int ADDR_W   = 19,
   parameter int LEN_W    = 12,
   parameter int WR_TICKS = 2
) (
   input  logic              clk_asic,
   input  logic              cd_rst_n,
   input  logic              sub_sync,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  remain,
   wram_cdc_dma_if.master    bus
);
   localparam int CNT_W = (WR_TICKS > 1) ? $clog2(WR_TICKS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_FIN} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_dat;
   logic [LEN_W-1:0]  r_remain;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_wr_end;

   // Last counted tick of a word write; held-off ticks never count.
   assign w_wr_end = (r_cnt == CNT_W'(WR_TICKS - 1)) & ~bus.wram_hold;

   // State register
   always_ff @(posedge clk_asic or negedge cd_rst_n) begin
      if (!cd_rst_n) begin
         r_state <= S_IDLE;
      end else if (sub_sync) begin
         r_state <= w_next;
      end
   end

   // Next-state logic; abort overrides everything, including a start in IDLE.
   always_comb begin
      w_next = r_state;
      if (sub_sync) begin
         if (abort) begin
            w_next = S_IDLE;
         end else begin
            case (r_state)
               S_IDLE:  if (start) w_next = (len == '0) ? S_FIN : S_FETCH;
               S_FETCH: if (bus.src_valid) w_next = S_WRITE;
               S_WRITE: if (w_wr_end) w_next = (r_remain == LEN_W'(1)) ? S_FIN : S_FETCH;
               S_FIN:   w_next = S_IDLE;
               default: w_next = S_IDLE;
            endcase
         end
      end
   end

   // Outputs decoded from the current state
   always_comb begin
      bus.src_ready   = 1'b0;
      bus.dma_ce_wram = 1'b0;
      bus.dma_we      = 1'b0;
      busy            = 1'b0;
      done            = 1'b0;
      case (r_state)
         S_FETCH: begin
            busy          = 1'b1;
            bus.src_ready = ~abort;
         end
         S_WRITE: begin
            busy            = 1'b1;
            bus.dma_ce_wram = 1'b1;
            bus.dma_we      = 1'b1;
         end
         S_FIN: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath: address, data, word count and per-word tick counter.
   // On abort only the tick counter is cleared so remain/addr report where the transfer stopped.
   always_ff @(posedge clk_asic or negedge cd_rst_n) begin
      if (!cd_rst_n) begin
         r_addr   <= '0;
         r_dat    <= '0;
         r_remain <= '0;
         r_cnt    <= '0;
      end else if (sub_sync) begin
         if (abort) begin
            r_cnt <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_addr   <= dst_addr & ~ADDR_W'(1);
                     r_remain <= len;
                     r_cnt    <= '0;
                  end
               end
               S_FETCH: begin
                  if (bus.src_valid) r_dat <= bus.src_data;
               end
               S_WRITE: begin
                  if (w_wr_end) begin
                     r_cnt    <= '0;
                     r_remain <= r_remain - LEN_W'(1);
                     r_addr   <= r_addr + ADDR_W'(2);
                  end else if (!bus.wram_hold) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign remain       = r_remain;
   assign bus.dma_addr = r_addr;
   assign bus.dma_dat  = r_dat;
endmodule

// File: tb/tb_wram_cdc_dma.sv
module tb_wram_cdc_dma;
   localparam int ADDR_W = 19;
   localparam int LEN_W  = 12;

   logic              clk_asic = 1'b0;
   logic              cd_rst_n = 1'b0;
   logic              sub_sync;
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] dst_addr;
   logic [LEN_W-1:0]  len;
   logic              busy;
   logic              done;
   logic [LEN_W-1:0]  remain;

   wram_cdc_dma_if #(.ADDR_W(ADDR_W)) bus ();

   wram_cdc_dma #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .WR_TICKS(2)) dut (
      .clk_asic (clk_asic),
      .cd_rst_n (cd_rst_n),
      .sub_sync (sub_sync),
      .start    (start),
      .abort    (abort),
      .dst_addr (dst_addr),
      .len      (len),
      .busy     (busy),
      .done     (done),
      .remain   (remain),
      .bus      (bus)
   );

   always #5 clk_asic = ~clk_asic;

   int n_checks = 0;
   int n_fail   = 0;

   // Source / tick-enable pattern controls
   bit src_en   = 1'b0;
   bit gap_mode = 1'b0;
   bit div3     = 1'b0;
   int src_idx  = 0;
   int cyc      = 0;

   // CDC buffer model: word n carries 16'hA000+n, advancing on each accepted handshake.
   initial begin : drv
      bit acc;
      sub_sync      = 1'b1;
      bus.src_valid = 1'b0;
      bus.src_data  = 16'hA000;
      forever begin
         @(posedge clk_asic);
         acc = bus.src_valid & bus.src_ready & sub_sync;
         #1;
         cyc++;
         if (acc) src_idx++;
         bus.src_data  = 16'hA000 + src_idx[15:0];
         bus.src_valid = src_en & (!gap_mode | (cyc % 4 == 0));
         sub_sync      = !div3 | (cyc % 3 == 0);
      end
   end

   // Write log: one entry per strobe pulse, with its length in ticks.
   logic [ADDR_W-1:0] wa_q[$];
   logic [15:0]       wd_q[$];
   int                wl_q[$];
   bit                in_s = 1'b0;
   logic [ADDR_W-1:0] cur_a;
   logic [15:0]       cur_d;
   int                cur_l;
   int                n_done, n_busy, n_unstable, n_rdy_bad;

   always @(negedge clk_asic) begin
      if (bus.dma_ce_wram === 1'b1) begin
         if (!in_s) begin
            in_s  = 1'b1;
            cur_a = bus.dma_addr;
            cur_d = bus.dma_dat;
            cur_l = 0;
         end else if (bus.dma_addr !== cur_a || bus.dma_dat !== cur_d) begin
            n_unstable++;
         end
         if (bus.dma_we !== 1'b1) n_unstable++;
         if (sub_sync) cur_l++;
      end else if (in_s) begin
         wa_q.push_back(cur_a);
         wd_q.push_back(cur_d);
         wl_q.push_back(cur_l);
         in_s = 1'b0;
      end
      if (sub_sync && done === 1'b1) n_done++;
      if (sub_sync && busy === 1'b1) n_busy++;
      if (bus.src_ready === 1'b1 && (bus.dma_ce_wram !== 1'b0 || busy !== 1'b1 || done !== 1'b0))
         n_rdy_bad++;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_asic);
         #2;
      end
   endtask

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
      wl_q.delete();
      n_done = 0; n_busy = 0; n_unstable = 0; n_rdy_bad = 0;
   endtask

   // Hold start until the engine reports busy (or a short bound runs out).
   task automatic do_start(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
      dst_addr = a;
      len      = l;
      start    = 1'b1;
      for (int i = 0; i < 12 && busy !== 1'b1; i++) step(1);
      start = 1'b0;
   endtask

   task automatic run_idle(input int max, output bit ok);
      int i;
      i = 0;
      while (busy !== 1'b0 && i < max) begin
         step(1);
         i++;
      end
      ok = (busy === 1'b0);
      step(2);
   endtask

   task automatic test_reset();
      start = 1'b0; abort = 1'b0; dst_addr = '0; len = '0; bus.wram_hold = 1'b0;
      cd_rst_n = 1'b0;
      step(3);
      n_checks++; if (busy !== 1'b0)            begin n_fail++; $display("FAIL rst_busy: got %0h want 0", busy); end
      n_checks++; if (done !== 1'b0)            begin n_fail++; $display("FAIL rst_done: got %0h want 0", done); end
      n_checks++; if (remain !== 12'd0)         begin n_fail++; $display("FAIL rst_remain: got %0h want 0", remain); end
      n_checks++; if (bus.dma_addr !== 19'h0)   begin n_fail++; $display("FAIL rst_addr: got %0h want 0", bus.dma_addr); end
      n_checks++; if (bus.dma_dat !== 16'h0)    begin n_fail++; $display("FAIL rst_dat: got %0h want 0", bus.dma_dat); end
      n_checks++; if (bus.dma_ce_wram !== 1'b0) begin n_fail++; $display("FAIL rst_ce: got %0h want 0", bus.dma_ce_wram); end
      n_checks++; if (bus.dma_we !== 1'b0)      begin n_fail++; $display("FAIL rst_we: got %0h want 0", bus.dma_we); end
      n_checks++; if (bus.src_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_ready: got %0h want 0", bus.src_ready); end
      cd_rst_n = 1'b1;
      step(2);
   endtask

   task automatic test_stream3();
      logic [ADDR_W-1:0] ea[3] = '{19'h08000, 19'h08002, 19'h08004};
      bit ok;
      int base;
      clear_log();
      src_en = 1'b1;
      base   = src_idx;
      do_start(19'h08000, 12'd3);
      n_checks++; if (remain !== 12'd3) begin n_fail++; $display("FAIL t1_remain_start: got %0d want 3", remain); end
      run_idle(60, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL t1_timeout: busy still %0h want 0", busy); end
      n_checks++; if (wl_q.size() != 3) begin n_fail++; $display("FAIL t1_nwrites: got %0d want 3", wl_q.size()); end
      for (int i = 0; i < 3 && i < wl_q.size(); i++) begin
         n_checks++; if (wa_q[i] !== ea[i]) begin n_fail++; $display("FAIL t1_addr%0d: got %0h want %0h", i, wa_q[i], ea[i]); end
         n_checks++; if (wd_q[i] !== 16'hA000 + 16'(base + i)) begin n_fail++; $display("FAIL t1_dat%0d: got %0h want %0h", i, wd_q[i], 16'hA000 + 16'(base + i)); end
         n_checks++; if (wl_q[i] != 2) begin n_fail++; $display("FAIL t1_len%0d: got %0d want 2", i, wl_q[i]); end
      end
      n_checks++; if (n_done != 1)      begin n_fail++; $display("FAIL t1_done: got %0d pulses want 1", n_done); end
      n_checks++; if (remain !== 12'd0) begin n_fail++; $display("FAIL t1_remain_end: got %0d want 0", remain); end
      n_checks++; if (n_busy != 10)     begin n_fail++; $display("FAIL t1_busy_ticks: got %0d want 10", n_busy); end
      n_checks++; if (n_unstable != 0)  begin n_fail++; $display("FAIL t1_stable: got %0d glitches want 0", n_unstable); end
   endtask

   task automatic test_len0();
      bit ok;
      clear_log();
      do_start(19'h00100, 12'd0);
      run_idle(10, ok);
      n_checks++; if (!ok)              begin n_fail++; $display("FAIL t2_timeout: busy %0h want 0", busy); end
      n_checks++; if (wl_q.size() != 0) begin n_fail++; $display("FAIL t2_nwrites: got %0d want 0", wl_q.size()); end
      n_checks++; if (n_busy != 1)      begin n_fail++; $display("FAIL t2_busy_ticks: got %0d want 1", n_busy); end
      n_checks++; if (n_done != 1)      begin n_fail++; $display("FAIL t2_done: got %0d want 1", n_done); end
      n_checks++; if (bus.dma_addr !== 19'h00100) begin n_fail++; $display("FAIL t2_addr: got %0h want 100", bus.dma_addr); end
   endtask

   task automatic test_hold();
      bit ok;
      int base;
      clear_log();
      base = src_idx;
      do_start(19'h01230, 12'd2);
      step(2);
      n_checks++; if (bus.dma_ce_wram !== 1'b1) begin n_fail++; $display("FAIL t3_ce_before_hold: got %0h want 1", bus.dma_ce_wram); end
      bus.wram_hold = 1'b1;
      step(5);
      n_checks++; if (bus.dma_ce_wram !== 1'b1) begin n_fail++; $display("FAIL t3_ce_in_hold: got %0h want 1", bus.dma_ce_wram); end
      n_checks++; if (remain !== 12'd2)         begin n_fail++; $display("FAIL t3_remain_in_hold: got %0d want 2", remain); end
      bus.wram_hold = 1'b0;
      run_idle(40, ok);
      n_checks++; if (wl_q.size() != 2) begin n_fail++; $display("FAIL t3_nwrites: got %0d want 2", wl_q.size()); end
      n_checks++; if (wl_q[0] != 7)     begin n_fail++; $display("FAIL t3_len0: got %0d want 7", wl_q[0]); end
      n_checks++; if (wl_q[1] != 2)     begin n_fail++; $display("FAIL t3_len1: got %0d want 2", wl_q[1]); end
      n_checks++; if (wa_q[0] !== 19'h01230 || wa_q[1] !== 19'h01232) begin n_fail++; $display("FAIL t3_addr: got %0h,%0h want 1230,1232", wa_q[0], wa_q[1]); end
      n_checks++; if (wd_q[1] !== 16'hA000 + 16'(base + 1)) begin n_fail++; $display("FAIL t3_dat1: got %0h want %0h", wd_q[1], 16'hA000 + 16'(base + 1)); end
      n_checks++; if (n_unstable != 0)  begin n_fail++; $display("FAIL t3_stable: got %0d glitches want 0", n_unstable); end
      n_checks++; if (!ok || n_done != 1) begin n_fail++; $display("FAIL t3_done: got %0d pulses (idle=%0d) want 1", n_done, ok); end
   endtask

   task automatic test_wrap();
      bit ok;
      clear_log();
      do_start(19'h7FFFF, 12'd2);
      run_idle(30, ok);
      n_checks++; if (wl_q.size() != 2) begin n_fail++; $display("FAIL t4_nwrites: got %0d want 2", wl_q.size()); end
      n_checks++; if (wa_q[0] !== 19'h7FFFE) begin n_fail++; $display("FAIL t4_addr0: got %0h want 7fffe", wa_q[0]); end
      n_checks++; if (wa_q[1] !== 19'h00000) begin n_fail++; $display("FAIL t4_addr1: got %0h want 0", wa_q[1]); end
      n_checks++; if (!ok || n_done != 1)    begin n_fail++; $display("FAIL t4_done: got %0d want 1", n_done); end
   endtask

   task automatic test_abort();
      bit ok;
      int base;
      clear_log();
      do_start(19'h10000, 12'd4);
      step(4);
      n_checks++; if (bus.dma_ce_wram !== 1'b1 || bus.dma_addr !== 19'h10002) begin n_fail++; $display("FAIL t5_second_write: ce=%0h addr=%0h want 1,10002", bus.dma_ce_wram, bus.dma_addr); end
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      n_checks++; if (bus.dma_ce_wram !== 1'b0 || bus.dma_we !== 1'b0) begin n_fail++; $display("FAIL t5_strobe: ce=%0h we=%0h want 0,0", bus.dma_ce_wram, bus.dma_we); end
      n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL t5_busy: got %0h want 0", busy); end
      n_checks++; if (remain !== 12'd3) begin n_fail++; $display("FAIL t5_remain: got %0d want 3", remain); end
      step(4);
      n_checks++; if (n_done != 0)      begin n_fail++; $display("FAIL t5_no_done: got %0d want 0", n_done); end
      n_checks++; if (wl_q.size() != 2 || wl_q[1] != 1) begin n_fail++; $display("FAIL t5_truncated: writes=%0d len1=%0d want 2,1", wl_q.size(), wl_q[1]); end
      // start and abort together in IDLE must not launch a transfer
      dst_addr = 19'h50000; len = 12'd7; start = 1'b1; abort = 1'b1;
      step(1);
      start = 1'b0; abort = 1'b0;
      step(1);
      n_checks++; if (busy !== 1'b0 || remain !== 12'd3) begin n_fail++; $display("FAIL t5_start_abort: busy=%0h remain=%0d want 0,3", busy, remain); end
      clear_log();
      base = src_idx;
      do_start(19'h00400, 12'd1);
      run_idle(30, ok);
      n_checks++; if (wl_q.size() != 1 || wa_q[0] !== 19'h00400) begin n_fail++; $display("FAIL t5_restart: writes=%0d addr=%0h want 1,400", wl_q.size(), wa_q[0]); end
      n_checks++; if (wd_q[0] !== 16'hA000 + 16'(base)) begin n_fail++; $display("FAIL t5_restart_dat: got %0h want %0h", wd_q[0], 16'hA000 + 16'(base)); end
      n_checks++; if (!ok || n_done != 1 || remain !== 12'd0) begin n_fail++; $display("FAIL t5_restart_done: done=%0d remain=%0d want 1,0", n_done, remain); end
   endtask

   task automatic test_start_while_busy();
      bit ok;
      clear_log();
      do_start(19'h20000, 12'd2);
      step(2);
      dst_addr = 19'h30000; len = 12'd5; start = 1'b1;
      step(1);
      start = 1'b0;
      run_idle(40, ok);
      n_checks++; if (wl_q.size() != 2) begin n_fail++; $display("FAIL sb_nwrites: got %0d want 2", wl_q.size()); end
      n_checks++; if (wa_q[0] !== 19'h20000 || wa_q[1] !== 19'h20002) begin n_fail++; $display("FAIL sb_addr: got %0h,%0h want 20000,20002", wa_q[0], wa_q[1]); end
      n_checks++; if (!ok || remain !== 12'd0) begin n_fail++; $display("FAIL sb_remain: got %0d want 0", remain); end
   endtask

   task automatic test_gapped_and_reset();
      logic [ADDR_W-1:0] ea[4] = '{19'h02000, 19'h02002, 19'h02004, 19'h02006};
      bit ok;
      bit seen;
      int base;
      div3 = 1'b1; gap_mode = 1'b1;
      step(3);
      clear_log();
      base = src_idx;
      do_start(19'h02000, 12'd4);
      run_idle(400, ok);
      n_checks++; if (!ok)              begin n_fail++; $display("FAIL t6_timeout: busy %0h want 0", busy); end
      n_checks++; if (wl_q.size() != 4) begin n_fail++; $display("FAIL t6_nwrites: got %0d want 4", wl_q.size()); end
      for (int i = 0; i < 4 && i < wl_q.size(); i++) begin
         n_checks++;
         if (wa_q[i] !== ea[i] || wd_q[i] !== 16'hA000 + 16'(base + i) || wl_q[i] != 2) begin
            n_fail++;
            $display("FAIL t6_write%0d: addr=%0h dat=%0h len=%0d want %0h,%0h,2", i, wa_q[i], wd_q[i], wl_q[i], ea[i], 16'hA000 + 16'(base + i));
         end
      end
      n_checks++; if (n_rdy_bad != 0) begin n_fail++; $display("FAIL t6_ready_scope: got %0d bad cycles want 0", n_rdy_bad); end
      n_checks++; if (n_done != 1)    begin n_fail++; $display("FAIL t6_done: got %0d want 1", n_done); end
      // async reset in the middle of a write
      clear_log();
      do_start(19'h03000, 12'd3);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (bus.dma_ce_wram === 1'b1) seen = 1'b1;
         else step(1);
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL t6_no_strobe: got none want strobe before reset"); end
      cd_rst_n = 1'b0;
      #1;
      n_checks++; if (bus.dma_ce_wram !== 1'b0 || bus.dma_we !== 1'b0) begin n_fail++; $display("FAIL t6_rst_strobe: ce=%0h we=%0h want 0,0", bus.dma_ce_wram, bus.dma_we); end
      n_checks++; if (busy !== 1'b0 || done !== 1'b0 || remain !== 12'd0) begin n_fail++; $display("FAIL t6_rst_status: busy=%0h done=%0h remain=%0d want 0,0,0", busy, done, remain); end
      n_checks++; if (bus.dma_addr !== 19'h0 || bus.dma_dat !== 16'h0 || bus.src_ready !== 1'b0) begin n_fail++; $display("FAIL t6_rst_bus: addr=%0h dat=%0h rdy=%0h want 0,0,0", bus.dma_addr, bus.dma_dat, bus.src_ready); end
      step(2);
      cd_rst_n = 1'b1;
      div3 = 1'b0; gap_mode = 1'b0;
      step(4);
      n_checks++; if (n_done != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL t6_post_rst: done=%0d busy=%0h want 0,0", n_done, busy); end
   endtask

   initial begin : main
      test_reset();
      test_stream3();
      test_len0();
      test_hold();
      test_wrap();
      test_abort();
      test_start_while_busy();
      test_gapped_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
